mux_arb_nto1: RTL and testbench
===============================

MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel, 1..32.
REQ-002 SHALL have parameter N, default 4: input channel count, 2..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-006 SHALL have port in_valid, input, N: channel i offers a word.
REQ-007 SHALL have port in_ready, output, N: channel i's word is taken this cycle.
REQ-008 SHALL have port mode, input, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-009 SHALL have port out_data, output, WIDTH: registered selected word.
REQ-010 SHALL have port out_sel, output, $clog2(N): index of the channel that supplied out_data.
REQ-011 SHALL have port out_valid, output, 1: out_data/out_sel hold a word.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the word.

Function
REQ-013 SHALL hold one-entry output register; accept = !out_valid | out_ready (combinational).
REQ-014 SHALL assert at most one in_ready bit per cycle: in_ready[g] = accept & in_valid[g] for granted channel g; all other bits 0.
REQ-015 SHALL, when no in_valid bit is set, drive in_ready all-zero and grant nothing.
REQ-016 SHALL, in mode 0, grant the lowest-index channel with in_valid set.
REQ-017 SHALL, in mode 1, grant the first channel with in_valid set searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-018 SHALL, on each handshake (in_valid[g] & in_ready[g]), load out_data = in_data of channel g, out_sel = g, out_valid = 1 at the next edge (latency 1 cycle).
REQ-019 SHALL, on a handshake in mode 1, set ptr = g+1, wrapping N-1 -> 0; ptr SHALL NOT change on cycles without a handshake or in mode 0.
REQ-020 SHALL, when out_valid & out_ready and no new handshake, clear out_valid next edge; out_data/out_sel keep their last values.
REQ-021 SHALL, when out_valid & out_ready and a new handshake occur together, replace the word with no bubble, giving full throughput of 1 word per cycle.
REQ-022 SHALL hold out_data and out_sel stable while out_valid & !out_ready (backpressure); in_ready all-zero then.
REQ-023 SHALL apply a mode change to the arbitration of the same cycle; ptr is preserved across mode changes.
REQ-024 SHALL keep grant decisions purely combinational from in_valid, mode and ptr; no input registered except via handshake.

Reset
REQ-025 SHALL, on rst_n low, clear immediately (asynchronously) out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-026 SHALL drive in_ready all-zero while rst_n is low.
REQ-027 SHALL discard any word held mid-operation when reset is asserted; no word is emitted after release until a new handshake.
REQ-028 SHALL allow the first handshake on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place default WIDTH, default N, and mode encodings MODE_FIXED=0 and MODE_RR=1 in shared package mux_pkg.
REQ-030 SHALL implement arbitration in one sub-module rr_arbiter (inputs req, ptr, mode; outputs one-hot grant, grant index); the output register stays in mux_arb_nto1.

Verification
REQ-031 SHALL verify: rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-032 SHALL verify: mode=0, in_valid=4'b1010, data ch1=8'hA1, ch3=8'hC3, out_ready=1 -> next cycle out_data=8'hA1, out_sel=1; ch1 is re-granted every cycle while valid.
REQ-033 SHALL verify: mode=1, in_valid=4'b1111 held, out_ready=1, for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
REQ-034 SHALL verify: out_ready=0 for 5 cycles with out_valid=1, out_data=8'h55 -> out_data stays 8'h55 and in_ready=0 throughout; on out_ready=1 the next word loads with no bubble.
REQ-035 SHALL verify: rst_n pulsed low mid-stream (out_valid=1, ptr=2) -> out_valid=0 and ptr=0 immediately; after release, in_valid=4'b1111 in mode 1 grants channel 0.
REQ-036 SHALL verify: N=8, WIDTH=16 with only ch7 valid (16'hBEEF) -> out_sel=7, out_data=16'hBEEF; in mode 1, ptr wraps to 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and arbitration mode encodings for the N-to-1 arbitrated mux.
package mux_pkg;
    localparam int   DEF_WIDTH  = 8;
    localparam int   DEF_N      = 4;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed-priority (from index 0) or round-robin (from ptr).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int   start_c;
    int   idx_c;
    logic found_c;

    // Scan N slots starting at start_c, wrapping; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_c   = 1'b0;
        idx_c     = 0;
        start_c   = (mode == MODE_RR) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx_c = start_c + k;
            if (idx_c >= N) begin
                idx_c = idx_c - N;
            end
            if (!found_c && req[idx_c]) begin
                found_c        = 1'b1;
                grant[idx_c]   = 1'b1;
                grant_idx      = IDX_W'(idx_c);
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrated multiplexer with a one-entry registered output (valid/ready).
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             accept;
    logic             hs;
    logic [WIDTH-1:0] data_sel;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0] out_sel_q,   out_sel_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The register is empty after reset, so gate with rst_n to keep in_ready low during reset.
    assign accept   = !out_valid_q || out_ready;
    assign in_ready = (accept && rst_n) ? grant : '0;
    assign hs       = |in_ready;

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                data_sel = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (hs) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel;
            out_sel_d   = grant_idx;
            if (mode == MODE_RR) begin
                ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: vector table plus hand-written multi-cycle sequences.
module tb_mux_arb_nto1;

    logic        clk;
    logic        rst_n;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic [127:0] in_data8;
    logic [7:0]   in_valid8;
    logic [7:0]   in_ready8;
    logic         mode8;
    logic [15:0]  out_data8;
    logic [2:0]   out_sel8;
    logic         out_valid8;
    logic         out_ready8;

    int errors = 0;
    int checks = 0;

    mux_arb_nto1 #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_arb_nto1 #(.WIDTH(16), .N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .mode      (mode8),
        .out_data  (out_data8),
        .out_sel   (out_sel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_os;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // mode, in_valid, out_ready, in_ready, next out_valid/out_data/out_sel
        vecs[0]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        vecs[1]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        vecs[6]  = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
        vecs[7]  = '{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
        vecs[8]  = '{1'b1, 4'b1110, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        vecs[9]  = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
        vecs[10] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA1, 2'd1};
        vecs[11] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};

        rst_n      = 1'b0;
        in_data    = 32'hC322A110;
        in_valid   = 4'b1111;
        mode       = 1'b0;
        out_ready  = 1'b1;
        in_data8   = '0;
        in_valid8  = '0;
        mode8      = 1'b0;
        out_ready8 = 1'b1;

        // Reset state with every channel requesting
        #12;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        check("rst_in_ready8", 32'(in_ready8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int v = 0; v < 12; v++) begin
            mode      = vecs[v].mode;
            in_valid  = vecs[v].vld;
            out_ready = vecs[v].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            tick();
            check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            check($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_od));
            check($sformatf("vec%0d_out_sel", v), 32'(out_sel), 32'(vecs[v].exp_os));
            @(negedge clk);
        end

        // Round-robin rotation from a fresh pointer
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("rr_sel%0d", c), 32'(out_sel), 32'(c % 4));
            check($sformatf("rr_valid%0d", c), 32'(out_valid), 32'h1);
        end
        @(negedge clk);

        // Backpressure holds the word, then the next word loads without a bubble
        mode     = 1'b0;
        in_data  = 32'h00006655;
        in_valid = 4'b0001;
        tick();
        check("bp_load", 32'(out_data), 32'h55);
        @(negedge clk);
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'h0);
            tick();
            check($sformatf("bp_data%0d", c), 32'(out_data), 32'h55);
            check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'h1);
            @(negedge clk);
        end
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        check("bp_next_data", 32'(out_data), 32'h66);
        check("bp_next_sel", 32'(out_sel), 32'h1);
        check("bp_next_valid", 32'(out_valid), 32'h1);
        @(negedge clk);

        // Mid-stream reset after two round-robin grants (pointer at 2)
        in_data  = 32'hC322A110;
        mode     = 1'b1;
        in_valid = 4'b1111;
        tick();
        check("mr_sel0", 32'(out_sel), 32'h0);
        tick();
        check("mr_sel1", 32'(out_sel), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'h0);
        check("mr_out_data", 32'(out_data), 32'h0);
        check("mr_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_first_sel", 32'(out_sel), 32'h0);
        check("mr_first_valid", 32'(out_valid), 32'h1);
        check("mr_first_data", 32'(out_data), 32'h10);
        @(negedge clk);
        in_valid = 4'b0000;

        // Wide configuration: only channel 7, then pointer wrap to 0
        mode8     = 1'b1;
        in_data8  = {16'hBEEF, 16'h6666, 16'h5555, 16'h4444,
                     16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        in_valid8 = 8'h80;
        #1;
        check("w_in_ready", 32'(in_ready8), 32'h80);
        tick();
        check("w_sel7", 32'(out_sel8), 32'h7);
        check("w_data", 32'(out_data8), 32'hBEEF);
        @(negedge clk);
        in_valid8 = 8'hFF;
        tick();
        check("w_wrap_sel", 32'(out_sel8), 32'h0);
        check("w_wrap_data", 32'(out_data8), 32'h0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
